qnet_qtp_rx: RTL and testbench
==============================

# qnet_qtp_rx

Receive-side QTP framer for the QICK network link. Consumes the raw 32-bit AXI-Stream from the link deserializer, reassembles the 96-bit QTP header into a `QTP_CTRL` word, and filters on destination and version. It forwards matching payload words downstream and checks them against `qtp_len`. It sits between the link PHY/deserializer and the node's packet consumer (port/memory write logic).

## Interface
- `DW`, 32: stream width; fixed to `AXIS_IN_DW`, so only 32 is supported.
- `QTP_VER`, 8'h01: accepted `qtp_version`.
- `clk_i`  in  1  single clock for the whole block.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `my_addr_i`  in  8  node address compared with `qtp_dst`; quasi-static.
- `s_axis_tdata_i`  in  32  link data.
- `s_axis_tvalid_i`  in  1  link data valid.
- `s_axis_tlast_i`  in  1  last word of the link frame.
- `s_axis_tready_o`  out  1  link ready.
- `m_axis_tdata_o`  out  32  payload data.
- `m_axis_tvalid_o`  out  1  payload valid.
- `m_axis_tlast_o`  out  1  last payload word.
- `m_axis_tready_i`  in  1  consumer ready.
- `hdr_o`  out  96  last accepted header, type `QTP_CTRL`.
- `hdr_vld_o`  out  1  one-cycle pulse when `hdr_o` updates.
- `err_len_o`  out  1  one-cycle pulse on a length/tlast mismatch.
- `err_ver_o`  out  1  one-cycle pulse on a version mismatch.
- `pkt_cnt_o`  out  16  count of accepted packets.
- `drop_cnt_o`  out  16  count of dropped packets.

## Operation
- **Header word order:**
  - W0 = `qtp_time[47:16]`
  - W1 = {`qtp_time[15:0]`, `qtp_version`, `qtp_cfg`}
  - W2 = {`qtp_ctrl`, `qtp_dst`, `qtp_len`}
- **States:**
  - `HDR`: word counter 0..2. `s_axis_tready_o`=1.
  - `PAY`: forward payload words. Ready is set by the skid buffer (not full).
  - `DROP`: sink words until the tlast word. `s_axis_tready_o`=1.
- **HDR:**
  - W0 and W1 are latched into a shadow register.
  - When W2 is accepted, the header is evaluated:
    - Version ≠ `QTP_VER`: pulse `err_ver_o`, increment `drop_cnt_o`, go to `DROP`.
    - `qtp_dst` ≠ `my_addr_i`: increment `drop_cnt_o`, go to `DROP`.
    - Otherwise the header is accepted. Load `hdr_o`, pulse `hdr_vld_o`, increment `pkt_cnt_o`.
  - If an accepted header has len=0:
    - W2 carrying tlast: return to `HDR`.
    - W2 without tlast: pulse `err_len_o`, go to `DROP`.
  - If an accepted header has len>0:
    - W2 carrying tlast: pulse `err_len_o`, return to `HDR`.
    - W2 without tlast: go to `PAY` with payload counter = `qtp_len`.
  - Tlast on W0 or W1: pulse `err_len_o`, increment `drop_cnt_o`, reset the word counter to 0.
- **PAY** (counter decrements on each accepted word):
  - Counter reaches 1 and the word carries tlast: forward with `m_axis_tlast_o`=1, go to `HDR`.
  - Counter reaches 1 and the word has no tlast: forward with `m_axis_tlast_o`=1, pulse `err_len_o`, go to `DROP`.
  - Tlast arrives while counter > 1: forward with `m_axis_tlast_o`=1, pulse `err_len_o`, go to `HDR`.
- **DROP:** on a tlast word, go to `HDR`.
- **Counters:** 16-bit, saturate at 16'hFFFF. The payload counter is 16 bits and never wraps.

## Timing
- **Reset values:**
  - All outputs are 0, including `s_axis_tready_o`, `hdr_o`, both counters and all pulses.
  - State = `HDR`, word counter = 0.
  - The skid buffer is emptied.
- **Header latency:** `hdr_vld_o` and the error pulses assert the cycle after the W2 handshake (registered).
- **Payload latency:** one cycle, s-handshake to `m_axis_tvalid_o`. Throughput is one word per cycle when `m_axis_tready_i`=1.
- **Skid buffer:** two entries.
  - `s_axis_tready_o` in `PAY` is registered: it is 1 when the buffer holds at most one entry.
  - No combinational path from `m_axis_tready_i` to `s_axis_tready_o`.
- **Output stability:** `m_axis_*` hold stable while `m_axis_tvalid_o`=1 and `m_axis_tready_i`=0.
- **Back-to-back packets:** W0 of the next packet may be accepted the cycle after the last word of the previous one, in any state. The skid buffer may still be draining.
- **Reset mid-packet:** the in-flight remainder is parsed as a header. The upstream link is reset together with this block.
- **Simultaneous events:** a version error and a dst mismatch on the same W2 give one drop (counted once) and `err_ver_o`.

## Configuration
- **`QNET_RX_BCAST_EN` defined:** `qtp_dst`=8'hFF is also accepted, in addition to `my_addr_i`.
- **`QNET_RX_BCAST_EN` undefined:** 8'hFF is treated as any other non-matching address and is dropped, unless `my_addr_i`=8'hFF.

## Structure
- **Shared defines package:**
  - `QTP_CTRL`
  - `QTP_VER` default
  - broadcast address 8'hFF
  - state enum `QTP_RX_ST` {`HDR`, `PAY`, `DROP`}
- **Sub-module:** `qnet_axis_skid`, a 2-entry registered skid buffer parameterized on width (33 bits: data + last).
- **Top level:** holds the FSM, header shadow registers and counters.

## Test plan
- **Valid packet:**
  - Stimulus: `my_addr_i`=8'h05; words 32'h0000_1234, 32'h5678_0100, 32'h0005_0003, followed by 3 payload words, the last with tlast.
  - Response: `hdr_o`.qtp_time=48'h0000_1234_5678, len=3, one `hdr_vld_o` pulse, 3 words out with tlast on the 3rd, `pkt_cnt_o`=1.
- **Wrong destination:**
  - Stimulus: same packet with dst=8'h06.
  - Response: no `m_axis` output, no `hdr_vld_o`, `drop_cnt_o`=1; a following valid packet is accepted.
- **Wrong version:**
  - Stimulus: version=8'h02.
  - Response: `err_ver_o` pulse, `drop_cnt_o`=1, payload discarded.
- **Length mismatch:**
  - Stimulus (a): len=4 with tlast on the 2nd payload word. Response: 2 words out, tlast on the 2nd, `err_len_o` pulse.
  - Stimulus (b): len=2 with 4 payload words. Response: 2 words out with tlast on the 2nd, `err_len_o` pulse, 2 words dropped.
- **Backpressure:**
  - Stimulus: `m_axis_tready_i` toggling 1/0 every cycle over a 16-word payload.
  - Response: no loss or duplication, data order preserved, `s_axis_tready_o` deasserts while the buffer is full.
- **Broadcast and reset:**
  - Stimulus: dst=8'hFF. Response: accepted only with `QNET_RX_BCAST_EN` defined.
  - Stimulus: assert `rst_i` mid-payload. Response: all outputs 0 next edge, counters cleared.

Source files
------------

// File: rtl/qnet_qtp_rx_pkg.sv
// Shared definitions for the QTP receive framer.
// Holds the header layout, the receive state encoding, the default protocol
// version, the broadcast address and a saturating counter helper.
package qnet_qtp_rx_pkg;

  // The link deserializer delivers 32-bit words; the header slicing depends on it.
  localparam int          AXIS_IN_DW     = 32;
  localparam logic [7:0]  QTP_VER_DEF    = 8'h01;
  localparam logic [7:0]  QTP_BCAST_ADDR = 8'hFF;

  // 96-bit QTP header, MSB first in the same order the words arrive:
  // W0 = time[47:16], W1 = {time[15:0], version, cfg}, W2 = {ctrl, dst, len}.
  typedef struct packed {
    logic [47:0] qtp_time;
    logic [7:0]  qtp_version;
    logic [7:0]  qtp_cfg;
    logic [7:0]  qtp_ctrl;
    logic [7:0]  qtp_dst;
    logic [15:0] qtp_len;
  } QTP_CTRL;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } QTP_RX_ST;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/qnet_axis_skid.sv
// Two-entry registered skid buffer.
// Upstream sees only a registered "full" flag, so there is no combinational
// path from m_ready_i back to the producer. Entry 0 is always the head; the
// head register changes only when it is popped or when the buffer is empty,
// which keeps m_data_o stable while m_valid_o=1 and m_ready_i=0.
module qnet_axis_skid #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_full_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] ent0_q;
  logic [W-1:0] ent1_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  // Push is ignored when full so a misbehaving producer cannot corrupt entries.
  always_comb begin
    push      = s_valid_i & (cnt_q != 2'd2);
    pop       = m_ready_i & (cnt_q != 2'd0);
    s_full_o  = (cnt_q == 2'd2);
    m_valid_o = (cnt_q != 2'd0);
    m_data_o  = ent0_q;
  end

  // Entry storage and occupancy update for every push/pop combination.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= s_data_i;
          else               ent1_q <= s_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the head advances and the new word queues behind.
          if (cnt_q == 2'd1) begin
            ent0_q <= s_data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= s_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/qnet_qtp_rx.sv
// QTP receive framer for the QICK network link.
// Reassembles the three header words, filters on version and destination,
// forwards payload through a 2-entry skid buffer and checks the payload
// length against tlast. Optional broadcast acceptance: QNET_RX_BCAST_EN.
//
// Handshakes: a word transfers on a rising clk edge where valid and ready are
// both 1; valid never waits on ready, and data/last stay stable while
// valid=1 and ready=0.
module qnet_qtp_rx
  import qnet_qtp_rx_pkg::*;
#(
  parameter int         DW      = AXIS_IN_DW,   // only 32 is supported
  parameter logic [7:0] QTP_VER = QTP_VER_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    my_addr_i,
  input  logic [DW-1:0] s_axis_tdata_i,
  input  logic          s_axis_tvalid_i,
  input  logic          s_axis_tlast_i,
  output logic          s_axis_tready_o,
  output logic [DW-1:0] m_axis_tdata_o,
  output logic          m_axis_tvalid_o,
  output logic          m_axis_tlast_o,
  input  logic          m_axis_tready_i,
  output logic [95:0]   hdr_o,
  output logic          hdr_vld_o,
  output logic          err_len_o,
  output logic          err_ver_o,
  output logic [15:0]   pkt_cnt_o,
  output logic [15:0]   drop_cnt_o
);

  QTP_RX_ST    state_q;
  logic [1:0]  wcnt_q;
  logic [31:0] w0_q;
  logic [31:0] w1_q;
  QTP_CTRL     hdr_q;
  QTP_CTRL     hdr_d;
  logic        hdr_vld_q;
  logic        err_len_q;
  logic        err_ver_q;
  logic        rdy_en_q;
  logic [15:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [15:0] pay_cnt_q;

  logic        s_ready;
  logic        s_fire;
  logic        ver_ok;
  logic        dst_ok;
  logic        push_vld;
  logic        push_last;
  logic        skid_full;
  logic [32:0] skid_out;

  // Ready comes only from registers: the reset-release flag, the state and
  // the skid occupancy. rdy_en_q keeps ready low throughout reset.
  always_comb begin
    s_ready   = rdy_en_q & ((state_q != PAY) | ~skid_full);
    s_fire    = s_axis_tvalid_i & s_ready;
    hdr_d     = {w0_q, w1_q, s_axis_tdata_i};
    ver_ok    = (hdr_d.qtp_version == QTP_VER);
`ifdef QNET_RX_BCAST_EN
    dst_ok    = (hdr_d.qtp_dst == my_addr_i) | (hdr_d.qtp_dst == QTP_BCAST_ADDR);
`else
    dst_ok    = (hdr_d.qtp_dst == my_addr_i);
`endif
    push_vld  = s_fire & (state_q == PAY);
    // The word that exhausts the length is marked last even if the link did not.
    push_last = s_axis_tlast_i | (pay_cnt_q == 16'd1);
  end

  qnet_axis_skid #(
    .W (33)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_data_i  ({push_last, s_axis_tdata_i}),
    .s_valid_i (push_vld),
    .s_full_o  (skid_full),
    .m_data_o  (skid_out),
    .m_valid_o (m_axis_tvalid_o),
    .m_ready_i (m_axis_tready_i)
  );

  // Receive FSM: header assembly, filtering, payload length tracking, counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HDR;
      wcnt_q     <= 2'd0;
      w0_q       <= '0;
      w1_q       <= '0;
      hdr_q      <= '0;
      hdr_vld_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_ver_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pay_cnt_q  <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      hdr_vld_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ver_q <= 1'b0;
      if (s_fire) begin
        case (state_q)
          HDR: begin
            if (wcnt_q != 2'd2) begin
              if (s_axis_tlast_i) begin
                // Frame ended inside the header: count it as a drop and resync.
                err_len_q  <= 1'b1;
                drop_cnt_q <= sat_inc16(drop_cnt_q);
                wcnt_q     <= 2'd0;
              end else begin
                if (wcnt_q == 2'd0) w0_q <= s_axis_tdata_i;
                else                w1_q <= s_axis_tdata_i;
                wcnt_q <= wcnt_q + 2'd1;
              end
            end else begin
              wcnt_q <= 2'd0;
              if (!ver_ok) begin
                // A version error wins over a destination miss; one drop either way.
                err_ver_q  <= 1'b1;
                drop_cnt_q <= sat_inc16(drop_cnt_q);
                if (!s_axis_tlast_i) state_q <= DROP;
              end else if (!dst_ok) begin
                drop_cnt_q <= sat_inc16(drop_cnt_q);
                if (!s_axis_tlast_i) state_q <= DROP;
              end else begin
                hdr_q     <= hdr_d;
                hdr_vld_q <= 1'b1;
                pkt_cnt_q <= sat_inc16(pkt_cnt_q);
                if (hdr_d.qtp_len == 16'd0) begin
                  if (!s_axis_tlast_i) begin
                    err_len_q <= 1'b1;
                    state_q   <= DROP;
                  end
                end else if (s_axis_tlast_i) begin
                  err_len_q <= 1'b1;
                end else begin
                  state_q   <= PAY;
                  pay_cnt_q <= hdr_d.qtp_len;
                end
              end
            end
          end
          PAY: begin
            pay_cnt_q <= pay_cnt_q - 16'd1;
            if (pay_cnt_q == 16'd1) begin
              if (s_axis_tlast_i) begin
                state_q <= HDR;
              end else begin
                err_len_q <= 1'b1;
                state_q   <= DROP;
              end
            end else if (s_axis_tlast_i) begin
              err_len_q <= 1'b1;
              state_q   <= HDR;
            end
          end
          DROP: begin
            if (s_axis_tlast_i) state_q <= HDR;
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

  // Output mapping; every output is a register or a skid-buffer register.
  always_comb begin
    s_axis_tready_o = s_ready;
    m_axis_tdata_o  = skid_out[31:0];
    m_axis_tlast_o  = skid_out[32];
    hdr_o           = hdr_q;
    hdr_vld_o       = hdr_vld_q;
    err_len_o       = err_len_q;
    err_ver_o       = err_ver_q;
    pkt_cnt_o       = pkt_cnt_q;
    drop_cnt_o      = drop_cnt_q;
  end

endmodule

// File: tb/tb_qnet_qtp_rx.sv
// Directed bench for qnet_qtp_rx: header filtering, length errors,
// backpressure, broadcast and reset mid-payload.
module tb_qnet_qtp_rx;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  my_addr_i;
  logic [31:0] s_axis_tdata_i;
  logic        s_axis_tvalid_i;
  logic        s_axis_tlast_i;
  logic        s_axis_tready_o;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tready_i = 1'b0;
  logic [95:0] hdr_o;
  logic        hdr_vld_o;
  logic        err_len_o;
  logic        err_ver_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] drop_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int hv_n  = 0;
  int el_n  = 0;
  int ev_n  = 0;
  bit saw_stall = 1'b0;
  bit bp_mode   = 1'b0;
  logic r_next;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  qnet_qtp_rx dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .my_addr_i       (my_addr_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tready_o (s_axis_tready_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tready_i (m_axis_tready_i),
    .hdr_o           (hdr_o),
    .hdr_vld_o       (hdr_vld_o),
    .err_len_o       (err_len_o),
    .err_ver_o       (err_ver_o),
    .pkt_cnt_o       (pkt_cnt_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Sink side: drives m_ready on the falling edge and records the word that
  // the next rising edge will consume; also counts the status pulses.
  always @(negedge clk) begin
    if (rst_i) begin
      m_axis_tready_i = 1'b0;
    end else begin
      r_next = bp_mode ? ~m_axis_tready_i : 1'b1;
      m_axis_tready_i = r_next;
      if (r_next && m_axis_tvalid_o) got_q.push_back({m_axis_tlast_o, m_axis_tdata_o});
      if (hdr_vld_o) hv_n++;
      if (err_len_o) el_n++;
      if (err_ver_o) ev_n++;
      if (s_axis_tvalid_i && !s_axis_tready_o) saw_stall = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present one word, wait (bounded) for ready, let one edge take it.
  task automatic send(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    s_axis_tdata_i  = d;
    s_axis_tlast_i  = l;
    s_axis_tvalid_i = 1'b1;
    while (!s_axis_tready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_ready_timeout", {95'd0, s_axis_tready_o}, 96'd1);
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    send(w0, 1'b0);
    send(w1, 1'b0);
    send(w2, 1'b0);
  endtask

  // Scoreboard: wait for the skid buffer to drain, then compare in order.
  task automatic cmp_stream(input string tag);
    logic [32:0] e;
    logic [32:0] g;
    repeat (40) @(negedge clk);
    check({tag, "_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
      else                  g = 33'h0;
      check({tag, "_word"}, {63'd0, g}, {63'd0, e});
    end
    got_q.delete();
  endtask

  initial begin
    rst_i           = 1'b1;
    my_addr_i       = 8'h05;
    s_axis_tdata_i  = '0;
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tready", {95'd0, s_axis_tready_o}, 96'd0);
    check("rst_mvalid", {95'd0, m_axis_tvalid_o}, 96'd0);
    check("rst_hdr", hdr_o, 96'd0);
    check("rst_pkt", {80'd0, pkt_cnt_o}, 96'd0);
    check("rst_drop", {80'd0, drop_cnt_o}, 96'd0);
    check("rst_pulses", {93'd0, hdr_vld_o, err_len_o, err_ver_o}, 96'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {95'd0, s_axis_tready_o}, 96'd1);

    // tlast on W0: length error, counted as a drop
    send(32'h0000_1234, 1'b1);
    check("w0_tlast_errlen", {95'd0, err_len_o}, 96'd1);
    check("w0_tlast_drop", {80'd0, drop_cnt_o}, 96'd1);

    // Valid packet, len=3
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0003);
    check("valid_hdr_vld", {95'd0, hdr_vld_o}, 96'd1);
    check("valid_hdr", hdr_o, 96'h0000_1234_5678_0100_0005_0003);
    send(32'h1111_0001, 1'b0);
    send(32'h1111_0002, 1'b0);
    send(32'h1111_0003, 1'b1);
    exp_q.push_back({1'b0, 32'h1111_0001});
    exp_q.push_back({1'b0, 32'h1111_0002});
    exp_q.push_back({1'b1, 32'h1111_0003});
    cmp_stream("valid");
    check("valid_pkt", {80'd0, pkt_cnt_o}, 96'd1);
    check("valid_hv_n", 96'(hv_n), 96'd1);

    // Wrong destination: silently dropped
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0006_0003);
    check("dst_no_hdr_vld", {95'd0, hdr_vld_o}, 96'd0);
    send(32'h2222_0001, 1'b0);
    send(32'h2222_0002, 1'b0);
    send(32'h2222_0003, 1'b1);
    cmp_stream("dst");
    check("dst_drop", {80'd0, drop_cnt_o}, 96'd2);
    check("dst_pkt", {80'd0, pkt_cnt_o}, 96'd1);
    check("dst_hv_n", 96'(hv_n), 96'd1);

    // Next valid packet still accepted
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0003);
    send(32'h3333_0001, 1'b0);
    send(32'h3333_0002, 1'b0);
    send(32'h3333_0003, 1'b1);
    exp_q.push_back({1'b0, 32'h3333_0001});
    exp_q.push_back({1'b0, 32'h3333_0002});
    exp_q.push_back({1'b1, 32'h3333_0003});
    cmp_stream("after_dst");
    check("after_dst_pkt", {80'd0, pkt_cnt_o}, 96'd2);

    // Wrong version
    send_hdr(32'h0000_1234, 32'h5678_0200, 32'h0005_0003);
    check("ver_err_pulse", {95'd0, err_ver_o}, 96'd1);
    send(32'h4444_0001, 1'b0);
    send(32'h4444_0002, 1'b0);
    send(32'h4444_0003, 1'b1);
    cmp_stream("ver");
    check("ver_drop", {80'd0, drop_cnt_o}, 96'd3);
    check("ver_ev_n", 96'(ev_n), 96'd1);
    check("ver_hv_n", 96'(hv_n), 96'd2);

    // Length mismatch (a): len=4, tlast on 2nd payload word
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0004);
    send(32'h5555_0001, 1'b0);
    send(32'h5555_0002, 1'b1);
    check("lena_errlen", {95'd0, err_len_o}, 96'd1);
    exp_q.push_back({1'b0, 32'h5555_0001});
    exp_q.push_back({1'b1, 32'h5555_0002});
    cmp_stream("lena");
    check("lena_hdr", hdr_o, 96'h0000_1234_5678_0100_0005_0004);
    check("lena_pkt", {80'd0, pkt_cnt_o}, 96'd3);

    // Length mismatch (b): len=2, four payload words
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0002);
    send(32'h6666_0001, 1'b0);
    send(32'h6666_0002, 1'b0);
    check("lenb_errlen", {95'd0, err_len_o}, 96'd1);
    send(32'h6666_0003, 1'b0);
    send(32'h6666_0004, 1'b1);
    exp_q.push_back({1'b0, 32'h6666_0001});
    exp_q.push_back({1'b1, 32'h6666_0002});
    cmp_stream("lenb");
    check("lenb_pkt", {80'd0, pkt_cnt_o}, 96'd4);
    check("lenb_drop", {80'd0, drop_cnt_o}, 96'd3);
    check("errlen_total", 96'(el_n), 96'd3);

    // Backpressure: consumer ready toggles every cycle over 16 words
    bp_mode   = 1'b1;
    saw_stall = 1'b0;
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0010);
    for (int i = 0; i < 16; i++) begin
      send(32'h7777_0000 + 32'(i), (i == 15));
      exp_q.push_back({(i == 15), 32'h7777_0000 + 32'(i)});
    end
    cmp_stream("bp");
    bp_mode = 1'b0;
    check("bp_stall_seen", {95'd0, saw_stall}, 96'd1);
    check("bp_pkt", {80'd0, pkt_cnt_o}, 96'd5);

    // Broadcast destination
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h00FF_0001);
    send(32'h8888_0001, 1'b1);
`ifdef QNET_RX_BCAST_EN
    exp_q.push_back({1'b1, 32'h8888_0001});
    cmp_stream("bcast");
    check("bcast_pkt", {80'd0, pkt_cnt_o}, 96'd6);
    check("bcast_drop", {80'd0, drop_cnt_o}, 96'd3);
`else
    cmp_stream("bcast");
    check("bcast_pkt", {80'd0, pkt_cnt_o}, 96'd5);
    check("bcast_drop", {80'd0, drop_cnt_o}, 96'd4);
`endif

    // Reset asserted mid-payload
    send_hdr(32'h0000_1234, 32'h5678_0100, 32'h0005_0004);
    send(32'h9999_0001, 1'b0);
    send(32'h9999_0002, 1'b0);
    rst_i = 1'b1;
    #1;
    check("midrst_tready", {95'd0, s_axis_tready_o}, 96'd0);
    check("midrst_mvalid", {95'd0, m_axis_tvalid_o}, 96'd0);
    check("midrst_mdata", {64'd0, m_axis_tdata_o}, 96'd0);
    check("midrst_hdr", hdr_o, 96'd0);
    check("midrst_pkt", {80'd0, pkt_cnt_o}, 96'd0);
    check("midrst_drop", {80'd0, drop_cnt_o}, 96'd0);
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Fresh packet after reset
    send_hdr(32'h0000_ABCD, 32'h0001_0100, 32'h0005_0001);
    send(32'hAAAA_0001, 1'b1);
    exp_q.push_back({1'b1, 32'hAAAA_0001});
    cmp_stream("post_rst");
    check("post_rst_hdr", hdr_o, 96'h0000_ABCD_0001_0100_0005_0001);
    check("post_rst_pkt", {80'd0, pkt_cnt_o}, 96'd1);
    check("post_rst_drop", {80'd0, drop_cnt_o}, 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
